odata_arbiter: RTL

Shares the single-bit registered `odata` output resource among `NREQ` requesters. Round-robin arbitration, level request/grant handshake, mandatory idle gap between owners. The granted requester's data bit is registered onto the shared `odata` line. The block sits between the requesting control modules and the downstream consumer of `odata`, replacing direct drive of that line.

---
 rtl/odata_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/odata_arbiter.sv
// odata_arbiter: round-robin arbiter sharing one registered odata line among
// NREQ level-handshake requesters, with a mandatory GAP_CYC idle gap between
// owners. Optional feature macro: ODATA_ARB_TIMEOUT_EN (forced release after
// HOLD_MAX grant cycles, flagged by a one-cycle timeout pulse). Without the
// macro there is no hold counter and timeout stays 0.

// Per-requester slice: only the current owner (its gnt bit set) contributes
// its data bit and its release indication to the shared reductions.
module odata_arbiter_lane (
    input  logic req,
    input  logic din,
    input  logic own,
    output logic dbit,
    output logic drop
);
    assign dbit = own & din;
    assign drop = own & ~req;
endmodule

module odata_arbiter #(
    parameter int NREQ     = 4,
    parameter int GAP_CYC  = 1,
    parameter int HOLD_MAX = 16
) (
    input  logic            sclk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] din,
    output logic [NREQ-1:0] gnt,
    output logic            odata,
    output logic            busy,
    output logic            timeout
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    // Reject out-of-range configurations at elaboration
    generate
        if (NREQ < 2 || NREQ > 16)
            $error("odata_arbiter: NREQ out of range 2..16");
        if (GAP_CYC < 1 || GAP_CYC > 15)
            $error("odata_arbiter: GAP_CYC out of range 1..15");
        if (HOLD_MAX < 2 || HOLD_MAX > 255)
            $error("odata_arbiter: HOLD_MAX out of range 2..255");
    endgenerate

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_d;
    logic            odata_d;
    logic            tmo_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [3:0]      gap_q, gap_d;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic [NREQ-1:0] lane_dbit, lane_drop;
    logic            own_dbit, own_drop;
    logic            hold_exp;

    // The registered one-hot grant doubles as the owner select, so no
    // owner index register is needed.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            odata_arbiter_lane u_lane (
                .req  (req[gi]),
                .din  (din[gi]),
                .own  (gnt[gi]),
                .dbit (lane_dbit[gi]),
                .drop (lane_drop[gi])
            );
        end
    endgenerate

    assign own_dbit = |lane_dbit;
    assign own_drop = |lane_drop;
    assign busy     = (state_q != S_IDLE);

    // Round-robin search: first set req bit starting at ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef ODATA_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    // Hold counter: cleared on grant, counts each GRANT cycle that keeps going
    always_comb begin
        hold_d = hold_q;
        if (state_q == S_IDLE && win_found)
            hold_d = '0;
        else if (state_q == S_GRANT && !own_drop && !hold_exp)
            hold_d = hold_q + 8'd1;
    end

    // Hold counter register
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) hold_q <= '0;
        else      hold_q <= hold_d;
    end

    assign hold_exp = (state_q == S_GRANT) && (hold_q == 8'(HOLD_MAX - 1));
`else
    assign hold_exp = 1'b0;
`endif

    // Next-state and output decode; a voluntary release wins over a timeout
    // that would expire on the same edge, so no pulse is raised then.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        odata_d = 1'b0;
        tmo_d   = 1'b0;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    gnt_d   = NREQ'(1) << win_idx;
                    ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            S_GRANT: begin
                if (own_drop) begin
                    state_d = S_GAP;
                    gnt_d   = '0;
                    gap_d   = '0;
                end else if (hold_exp) begin
                    state_d = S_GAP;
                    gnt_d   = '0;
                    gap_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    odata_d = own_dbit;
                end
            end
            S_GAP: begin
                gnt_d = '0;
                if (gap_q == 4'(GAP_CYC - 1))
                    state_d = S_IDLE;
                else
                    gap_d = gap_q + 4'd1;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt     <= '0;
            odata   <= 1'b0;
            timeout <= 1'b0;
            ptr_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            odata   <= odata_d;
            timeout <= tmo_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
        end
    end
endmodule
